// File: rtl/rat_recovery_ctrl.sv
// rtl/rat_recovery_ctrl.sv - rename-stage misprediction recovery sequencer (RRAT -> RAT copy, free-list restore)
// Optional counters: define RAT_RECOVERY_PERF_EN for perf_rec_count_o / perf_stall_cycles_o.
module rat_recovery_ctrl #(
    parameter int ARCH_REGS     = 32,
    parameter int PHYS_REG_BITS = 6,
    parameter int COPY_WIDTH    = 4,
    parameter int IDX_BITS      = $clog2(ARCH_REGS)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_req_i,
    input  logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0]   rrat_map_i,
    output logic                                      rat_we_o,
    output logic [IDX_BITS-1:0]                       rat_waddr_base_o,
    output logic [COPY_WIDTH-1:0][PHYS_REG_BITS-1:0]  rat_wdata_o,
    output logic [COPY_WIDTH-1:0]                     rat_wmask_o,
    output logic                                      fl_restore_o,
    output logic                                      stall_o,
    output logic                                      rec_done_o
`ifdef RAT_RECOVERY_PERF_EN
    ,
    output logic [31:0]                               perf_rec_count_o,
    output logic [31:0]                               perf_stall_cycles_o
`endif
);

    // One extra index bit so idx+COPY_WIDTH cannot wrap when ARCH_REGS is a power of two.
    localparam int CNT_W = IDX_BITS + 1;
    localparam logic [CNT_W-1:0] CW = CNT_W'(COPY_WIDTH);
    localparam logic [CNT_W-1:0] AR = CNT_W'(ARCH_REGS);

    typedef enum logic [1:0] {IDLE, COPY, FL_FIX, DONE} state_e;

    state_e                                 state_q, state_d;
    logic [CNT_W-1:0]                       idx_q, idx_d;
    logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0] snap_q;
    logic [CNT_W-1:0]                       idx_nxt;
    logic                                   accept;

    assign idx_nxt = idx_q + CW;
    assign accept  = (state_q == IDLE) && flush_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                snap_q    <= rrat_map_i;
                snap_q[0] <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                idx_d = idx_nxt;
                if (idx_nxt >= AR) begin
                    state_d = FL_FIX;
                end
            end
            FL_FIX:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rat_we_o         = (state_q == COPY);
        fl_restore_o     = (state_q == FL_FIX);
        rec_done_o       = (state_q == DONE);
        stall_o          = (state_q != IDLE);
        rat_waddr_base_o = (state_q == COPY) ? idx_q[IDX_BITS-1:0] : '0;
    end

    // Lanes past the last arch register carry zero data and no enable; x0 is never written.
    for (genvar k = 0; k < COPY_WIDTH; k++) begin : g_lane
        logic [CNT_W-1:0] lane_idx;
        logic             in_range;
        assign lane_idx        = idx_q + CNT_W'(k);
        assign in_range        = (lane_idx < AR);
        assign rat_wmask_o[k]  = rat_we_o && in_range && (lane_idx != '0);
        assign rat_wdata_o[k]  = (rat_we_o && in_range) ? snap_q[lane_idx[IDX_BITS-1:0]] : '0;
    end

`ifdef RAT_RECOVERY_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_rec_count_o    <= '0;
            perf_stall_cycles_o <= '0;
        end else begin
            if (accept && (perf_rec_count_o != '1)) begin
                perf_rec_count_o <= perf_rec_count_o + 32'd1;
            end
            if (stall_o && (perf_stall_cycles_o != '1)) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// tb/tb_rat_recovery_ctrl.sv - self-checking bench for rat_recovery_ctrl (COPY_WIDTH 4 and 5 instances)
module tb_rat_recovery_ctrl;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush4 = 1'b0;
    logic             flush5 = 1'b0;
    logic [31:0][5:0] rrat_map = '0;

    logic             we4, fl4, stall4, done4;
    logic [4:0]       base4;
    logic [3:0][5:0]  wdata4;
    logic [3:0]       mask4;
    logic             we5, fl5, stall5, done5;
    logic [4:0]       base5;
    logic [4:0][5:0]  wdata5;
    logic [4:0]       mask5;
`ifdef RAT_RECOVERY_PERF_EN
    logic [31:0]      prc4, psc4, prc5, psc5;
`endif

    int checks = 0;
    int errors = 0;
    int exp_rec4 = 0;
    int exp_stall4 = 0;
    logic [5:0] cap [32];

    always #5 clk = ~clk;

    rat_recovery_ctrl #(.ARCH_REGS(32), .PHYS_REG_BITS(6), .COPY_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush4), .rrat_map_i(rrat_map),
        .rat_we_o(we4), .rat_waddr_base_o(base4), .rat_wdata_o(wdata4), .rat_wmask_o(mask4),
        .fl_restore_o(fl4), .stall_o(stall4), .rec_done_o(done4)
`ifdef RAT_RECOVERY_PERF_EN
        , .perf_rec_count_o(prc4), .perf_stall_cycles_o(psc4)
`endif
    );

    rat_recovery_ctrl #(.ARCH_REGS(32), .PHYS_REG_BITS(6), .COPY_WIDTH(5)) dut5 (
        .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush5), .rrat_map_i(rrat_map),
        .rat_we_o(we5), .rat_waddr_base_o(base5), .rat_wdata_o(wdata5), .rat_wmask_o(mask5),
        .fl_restore_o(fl5), .stall_o(stall5), .rec_done_o(done5)
`ifdef RAT_RECOVERY_PERF_EN
        , .perf_rec_count_o(prc5), .perf_stall_cycles_o(psc5)
`endif
    );

    task automatic sample(input int w, output logic we, output int base, output logic [4:0] mask,
                          output logic [4:0][5:0] data, output logic fl, output logic dn, output logic st);
        if (w == 4) begin
            we = we4; base = int'(base4); mask = {1'b0, mask4}; data = {6'b0, wdata4};
            fl = fl4; dn = done4; st = stall4;
        end else begin
            we = we5; base = int'(base5); mask = mask5; data = wdata5;
            fl = fl5; dn = done5; st = stall5;
        end
    endtask

    task automatic randomize_map();
        for (int i = 0; i < 32; i++) rrat_map[i] = 6'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rec4 = 0;
        exp_stall4 = 0;
    endtask

    // Expected schedule: ceil(32/w) copy cycles, base j*w, lane k covers arch reg j*w+k,
    // then one free-list restore cycle, one done cycle, then idle.
    task automatic do_recovery(input string tag, input int w, input bit chg_map, input int ign1, input int ign2);
        int nc, a;
        logic we, fl, dn, st, em;
        int base;
        logic [4:0] mask;
        logic [4:0][5:0] data;
        logic [5:0] ed;
        nc = (32 + w - 1) / w;
        for (int i = 0; i < 32; i++) cap[i] = (i == 0) ? 6'd0 : rrat_map[i];
        sample(w, we, base, mask, data, fl, dn, st);
        checks++;
        if (st !== 1'b0) begin errors++; $display("FAIL %s pre_stall got %b exp 0", tag, st); end
        if (w == 4) flush4 = 1'b1; else flush5 = 1'b1;
        @(negedge clk);
        flush4 = 1'b0; flush5 = 1'b0;
        for (int j = 0; j <= nc + 2; j++) begin
            sample(w, we, base, mask, data, fl, dn, st);
            checks++;
            if (st !== (j <= nc + 1)) begin errors++; $display("FAIL %s stall j=%0d got %b exp %b", tag, j, st, (j <= nc + 1)); end
            checks++;
            if (we !== (j < nc)) begin errors++; $display("FAIL %s rat_we j=%0d got %b exp %b", tag, j, we, (j < nc)); end
            checks++;
            if (fl !== (j == nc)) begin errors++; $display("FAIL %s fl_restore j=%0d got %b exp %b", tag, j, fl, (j == nc)); end
            checks++;
            if (dn !== (j == nc + 1)) begin errors++; $display("FAIL %s rec_done j=%0d got %b exp %b", tag, j, dn, (j == nc + 1)); end
            if (j < nc) begin
                checks++;
                if (base !== j * w) begin errors++; $display("FAIL %s base j=%0d got %0d exp %0d", tag, j, base, j * w); end
                for (int k = 0; k < w; k++) begin
                    a  = j * w + k;
                    em = (a < 32) && (a != 0);
                    ed = (a < 32) ? cap[a] : 6'd0;
                    checks++;
                    if (mask[k] !== em) begin errors++; $display("FAIL %s wmask j=%0d lane=%0d got %b exp %b", tag, j, k, mask[k], em); end
                    checks++;
                    if (data[k] !== ed) begin errors++; $display("FAIL %s wdata j=%0d lane=%0d got %0d exp %0d", tag, j, k, data[k], ed); end
                end
            end
            if (chg_map) randomize_map();
            if (w == 4) flush4 = (j == ign1 || j == ign2); else flush5 = (j == ign1 || j == ign2);
            @(negedge clk);
        end
        flush4 = 1'b0; flush5 = 1'b0;
        if (w == 4) begin
            exp_rec4++;
            exp_stall4 += nc + 2;
`ifdef RAT_RECOVERY_PERF_EN
            checks++;
            if (prc4 !== 32'(exp_rec4)) begin errors++; $display("FAIL %s perf_rec_count got %0d exp %0d", tag, prc4, exp_rec4); end
            checks++;
            if (psc4 !== 32'(exp_stall4)) begin errors++; $display("FAIL %s perf_stall_cycles got %0d exp %0d", tag, psc4, exp_stall4); end
`endif
        end
    endtask

    task automatic test_reset();
        logic we, fl, dn, st;
        int base;
        logic [4:0] mask;
        logic [4:0][5:0] data;
        for (int w = 4; w <= 5; w++) begin
            sample(w, we, base, mask, data, fl, dn, st);
            checks++;
            if ({we, fl, dn, st} !== 4'b0) begin errors++; $display("FAIL reset_ctrl w=%0d got %b exp 0000", w, {we, fl, dn, st}); end
            checks++;
            if (mask !== 5'b0) begin errors++; $display("FAIL reset_mask w=%0d got %b exp 0", w, mask); end
        end
    endtask

    task automatic test_identity();
        for (int i = 0; i < 32; i++) rrat_map[i] = 6'(i);
        do_recovery("identity", 4, 1'b0, -1, -1);
    endtask

    task automatic test_offset_map();
        for (int i = 0; i < 32; i++) rrat_map[i] = 6'(i + 32);
        rrat_map[0] = 6'd7;
        do_recovery("offset", 4, 1'b0, -1, -1);
    endtask

    task automatic test_map_change();
        randomize_map();
        do_recovery("map_change", 4, 1'b1, -1, -1);
    endtask

    task automatic test_cw5();
        randomize_map();
        do_recovery("cw5", 5, 1'b0, -1, -1);
    endtask

    task automatic test_ignore_flush();
        apply_reset();
        randomize_map();
        do_recovery("ignore", 4, 1'b0, 2, 9);
    endtask

    task automatic test_reset_mid();
        randomize_map();
        flush4 = 1'b1;
        @(negedge clk);
        flush4 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({we4, fl4, done4, stall4} !== 4'b0) begin errors++; $display("FAIL reset_mid_ctrl got %b exp 0000", {we4, fl4, done4, stall4}); end
        checks++;
        if (mask4 !== 4'b0) begin errors++; $display("FAIL reset_mid_mask got %b exp 0", mask4); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rec4 = 0;
        exp_stall4 = 0;
        randomize_map();
        do_recovery("after_reset", 4, 1'b0, -1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            randomize_map();
            do_recovery("random", ($urandom_range(1) == 0) ? 4 : 5, 1'($urandom_range(1)), -1, -1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_identity();
        test_offset_map();
        test_map_change();
        test_cw5();
        test_ignore_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
